// File: rtl/mode_counter.sv
// Up/down counter over 0..MAX_VAL with enable, synchronous clear, clamped
// parallel load, wrap-or-saturate range ends, terminal count and sticky overflow.
module mode_counter #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             dir,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nq,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] d_clamp;
    logic             at_max;
    logic             at_zero;
    logic             cnt_act;
    logic             evt;

    // Range ends are compared against MAX_VAL, so arithmetic is modulo MAX_VAL+1.
    always_comb begin
        at_max  = (q == MAX_VAL);
        at_zero = (q == '0);
        cnt_act = en & ~clr & ~load;
        evt     = cnt_act & (dir ? at_max : at_zero);
        d_clamp = (d > MAX_VAL) ? MAX_VAL : d;
    end

    always_comb begin
        q_nxt = q;
        if (clr) begin
            q_nxt = '0;
        end else if (load) begin
            q_nxt = d_clamp;
        end else if (en) begin
            if (dir) begin
                if (at_max) q_nxt = SATURATE ? q : '0;
                else        q_nxt = q + ONE;
            end else begin
                if (at_zero) q_nxt = SATURATE ? q : MAX_VAL;
                else         q_nxt = q - ONE;
            end
        end
    end

    assign tc = evt;
    assign nq = ~q;

    // A range-end event on the same edge as ovf_clr keeps ovf set.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            q    <= '0;
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            q    <= q_nxt;
            wrap <= evt;
            ovf  <= evt | (ovf & ~ovf_clr);
        end
    end

endmodule

// File: tb/tb_mode_counter.sv
// Bench for mode_counter: a wrapping and a saturating instance (WIDTH=4,
// MAX_VAL=9) share stimulus; directed scenarios then randomized traffic.
module tb_mode_counter;

    localparam int MAXV = 9;

    logic       clk = 1'b0;
    logic       rstb, en, clr, load, dir, ovf_clr;
    logic [3:0] d;
    logic [3:0] q_w, nq_w, q_s, nq_s;
    logic       tc_w, wrap_w, ovf_w, tc_s, wrap_s, ovf_s;

    int vectors = 0;
    int errors  = 0;

    int mq[2];
    bit mwrap[2];
    bit movf[2];

    always #5 clk = ~clk;

    mode_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rstb(rstb), .en(en), .clr(clr), .load(load), .d(d), .dir(dir),
        .ovf_clr(ovf_clr), .q(q_w), .nq(nq_w), .tc(tc_w), .wrap(wrap_w), .ovf(ovf_w));

    mode_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rstb(rstb), .en(en), .clr(clr), .load(load), .d(d), .dir(dir),
        .ovf_clr(ovf_clr), .q(q_s), .nq(nq_s), .tc(tc_s), .wrap(wrap_s), .ovf(ovf_s));

    // Reference: index 0 wraps modulo MAXV+1, index 1 clamps to 0..MAXV.
    task automatic model_edge();
        int nx;
        bit ev;
        for (int s = 0; s < 2; s++) begin
            ev = 1'b0;
            if (clr) mq[s] = 0;
            else if (load) mq[s] = (int'(d) > MAXV) ? MAXV : int'(d);
            else if (en) begin
                nx = dir ? mq[s] + 1 : mq[s] - 1;
                ev = (nx > MAXV) || (nx < 0);
                if (s == 1) mq[s] = (nx > MAXV) ? MAXV : (nx < 0) ? 0 : nx;
                else        mq[s] = (nx + MAXV + 1) % (MAXV + 1);
            end
            mwrap[s] = ev;
            movf[s]  = ev | (movf[s] & !ovf_clr);
        end
    endtask

    function automatic bit exp_tc(int s);
        return en && !clr && !load && ((dir && mq[s] == MAXV) || (!dir && mq[s] == 0));
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            mq[s] = 0; mwrap[s] = 1'b0; movf[s] = 1'b0;
        end
    endtask

    task automatic drive(input bit c, input bit l, input int dd, input bit e, input bit dr, input bit oc);
        clr = c; load = l; d = 4'(dd); en = e; dir = dr; ovf_clr = oc;
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        drive(0, 0, 0, 0, 1, 0);
        model_reset();
        #3;
        vectors++;
        if ({q_w, nq_w, wrap_w, ovf_w, q_s, nq_s, wrap_s, ovf_s} !== {4'd0, 4'hF, 2'b00, 4'd0, 4'hF, 2'b00}) begin
            errors++;
            $display("FAIL reset: got q=%0d nq=%h wrap=%b ovf=%b / q=%0d nq=%h wrap=%b ovf=%b, want q=0 nq=f wrap=0 ovf=0",
                     q_w, nq_w, wrap_w, ovf_w, q_s, nq_s, wrap_s, ovf_s);
        end
        @(negedge clk);
        @(negedge clk);
        rstb = 1'b1;
    endtask

    task automatic test_count_up();
        logic [3:0] eq;
        for (int i = 0; i < 12; i++) begin
            drive(0, 0, 0, 1, 1, 0);
            #1;
            vectors++;
            if (tc_w !== (i == 9)) begin
                errors++;
                $display("FAIL up_tc[%0d]: got %b want %b", i, tc_w, (i == 9));
            end
            edge_step();
            eq = 4'((i + 1) % 10);
            vectors++;
            if ({q_w, nq_w, wrap_w, ovf_w} !== {eq, ~eq, 1'(i == 9), 1'(i >= 9)}) begin
                errors++;
                $display("FAIL up_q[%0d]: got q=%0d nq=%h wrap=%b ovf=%b want q=%0d wrap=%b ovf=%b",
                         i, q_w, nq_w, wrap_w, ovf_w, eq, (i == 9), (i >= 9));
            end
        end
    endtask

    task automatic test_count_down();
        drive(1, 0, 0, 0, 1, 1);
        edge_step();
        vectors++;
        if ({q_w, wrap_w, ovf_w} !== {4'd0, 2'b00}) begin
            errors++;
            $display("FAIL dn_clr: got q=%0d wrap=%b ovf=%b want q=0 wrap=0 ovf=0", q_w, wrap_w, ovf_w);
        end
        drive(0, 0, 0, 1, 0, 0);
        edge_step();
        vectors++;
        if ({q_w, wrap_w, ovf_w} !== {4'd9, 2'b11}) begin
            errors++;
            $display("FAIL dn_under: got q=%0d wrap=%b ovf=%b want q=9 wrap=1 ovf=1", q_w, wrap_w, ovf_w);
        end
        edge_step();
        vectors++;
        if ({q_w, wrap_w, ovf_w} !== {4'd8, 2'b01}) begin
            errors++;
            $display("FAIL dn_next: got q=%0d wrap=%b ovf=%b want q=8 wrap=0 ovf=1", q_w, wrap_w, ovf_w);
        end
    endtask

    task automatic test_saturate();
        drive(0, 1, 9, 0, 1, 0);
        edge_step();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 1, 0);
            #1;
            vectors++;
            if (tc_s !== 1'b1) begin
                errors++;
                $display("FAIL sat_tc[%0d]: got %b want 1", i, tc_s);
            end
            edge_step();
            vectors++;
            if ({q_s, wrap_s, ovf_s} !== {4'd9, 2'b11}) begin
                errors++;
                $display("FAIL sat_hold[%0d]: got q=%0d wrap=%b ovf=%b want q=9 wrap=1 ovf=1", i, q_s, wrap_s, ovf_s);
            end
        end
        drive(0, 0, 0, 1, 0, 0);
        edge_step();
        vectors++;
        if ({q_s, wrap_s} !== {4'd8, 1'b0}) begin
            errors++;
            $display("FAIL sat_down: got q=%0d wrap=%b want q=8 wrap=0", q_s, wrap_s);
        end
    endtask

    task automatic test_load();
        drive(0, 1, 15, 1, 1, 0);
        edge_step();
        vectors++;
        if ({q_w, wrap_w, q_s, wrap_s} !== {4'd9, 1'b0, 4'd9, 1'b0}) begin
            errors++;
            $display("FAIL load_clamp: got q=%0d/%0d wrap=%b/%b want q=9 wrap=0", q_w, q_s, wrap_w, wrap_s);
        end
        drive(1, 1, 5, 1, 1, 0);
        edge_step();
        vectors++;
        if ({q_w, q_s} !== {4'd0, 4'd0}) begin
            errors++;
            $display("FAIL clr_over_load: got q=%0d/%0d want 0", q_w, q_s);
        end
        drive(0, 1, 7, 0, 0, 0);
        edge_step();
        vectors++;
        if ({q_w, wrap_w, q_s} !== {4'd7, 1'b0, 4'd7}) begin
            errors++;
            $display("FAIL load_noen: got q=%0d/%0d wrap=%b want q=7 wrap=0", q_w, q_s, wrap_w);
        end
    endtask

    task automatic test_ovf_clr();
        vectors++;
        if (ovf_w !== 1'b1) begin
            errors++;
            $display("FAIL ovf_pre: got %b want 1", ovf_w);
        end
        drive(0, 1, 9, 0, 1, 0);
        edge_step();
        drive(0, 0, 0, 1, 1, 1);
        edge_step();
        vectors++;
        if ({q_w, wrap_w, ovf_w} !== {4'd0, 2'b11}) begin
            errors++;
            $display("FAIL ovf_set_wins: got q=%0d wrap=%b ovf=%b want q=0 wrap=1 ovf=1", q_w, wrap_w, ovf_w);
        end
        drive(0, 0, 0, 0, 1, 1);
        edge_step();
        vectors++;
        if ({q_w, wrap_w, ovf_w} !== {4'd0, 2'b00}) begin
            errors++;
            $display("FAIL ovf_clear: got q=%0d wrap=%b ovf=%b want q=0 wrap=0 ovf=0", q_w, wrap_w, ovf_w);
        end
    endtask

    task automatic test_async_reset();
        drive(0, 1, 9, 0, 1, 0); edge_step();
        drive(0, 0, 0, 1, 1, 0); edge_step();
        drive(0, 1, 5, 0, 1, 0); edge_step();
        drive(0, 0, 0, 1, 1, 0); edge_step();
        vectors++;
        if ({q_w, ovf_w, q_s, ovf_s} !== {4'd6, 1'b1, 4'd6, 1'b1}) begin
            errors++;
            $display("FAIL arst_pre: got q=%0d/%0d ovf=%b/%b want q=6 ovf=1", q_w, q_s, ovf_w, ovf_s);
        end
        #2 rstb = 1'b0;
        #1;
        vectors++;
        if ({q_w, nq_w, wrap_w, ovf_w, q_s, wrap_s, ovf_s} !== {4'd0, 4'hF, 2'b00, 4'd0, 2'b00}) begin
            errors++;
            $display("FAIL arst_now: got q=%0d nq=%h wrap=%b ovf=%b sat q=%0d wrap=%b ovf=%b want all cleared",
                     q_w, nq_w, wrap_w, ovf_w, q_s, wrap_s, ovf_s);
        end
        @(negedge clk);
        rstb = 1'b1;
        model_reset();
        edge_step();
        vectors++;
        if ({q_w, wrap_w, ovf_w, q_s} !== {4'd1, 2'b00, 4'd1}) begin
            errors++;
            $display("FAIL arst_resume: got q=%0d/%0d wrap=%b ovf=%b want q=1 wrap=0 ovf=0", q_w, q_s, wrap_w, ovf_w);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            drive(($urandom_range(15, 0) == 0), ($urandom_range(7, 0) == 0), int'($urandom_range(15, 0)),
                  ($urandom_range(3, 0) != 0), 1'($urandom), ($urandom_range(5, 0) == 0));
            #1;
            vectors++;
            if ({tc_w, tc_s} !== {exp_tc(0), exp_tc(1)}) begin
                errors++;
                $display("FAIL rnd_tc[%0d]: got %b/%b want %b/%b", i, tc_w, tc_s, exp_tc(0), exp_tc(1));
            end
            edge_step();
            vectors++;
            if ({q_w, nq_w, wrap_w, ovf_w} !== {4'(mq[0]), ~4'(mq[0]), mwrap[0], movf[0]}) begin
                errors++;
                $display("FAIL rnd_wrap[%0d]: got q=%0d nq=%h wrap=%b ovf=%b want q=%0d wrap=%b ovf=%b",
                         i, q_w, nq_w, wrap_w, ovf_w, mq[0], mwrap[0], movf[0]);
            end
            vectors++;
            if ({q_s, nq_s, wrap_s, ovf_s} !== {4'(mq[1]), ~4'(mq[1]), mwrap[1], movf[1]}) begin
                errors++;
                $display("FAIL rnd_sat[%0d]: got q=%0d nq=%h wrap=%b ovf=%b want q=%0d wrap=%b ovf=%b",
                         i, q_s, nq_s, wrap_s, ovf_s, mq[1], mwrap[1], movf[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_saturate();
        test_load();
        test_ovf_clr();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
